stopwatch_counter: RTL and testbench
====================================

Name: stopwatch_counter

Overview:
- Timing core of the stopwatch and the stage directly upstream of the per-digit lap registers.
- Runs a 4-digit BCD time count in M:SS.t format, advanced by an external tick enable.
- A start/stop/lap/clear state machine controls the count.
- Emits the four digit values plus a one-cycle lap strobe; the lap registers capture the current time on that strobe.

Parameters:
- SEC_TENS_MOD, 6, modulus of digit 2 (tens of seconds); legal range 2..10.
- LAP_CNT_W, 4, width of the saturating lap counter.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- tick  input  1  one-cycle enable at the count rate (10 Hz for tenths); may arrive in any cycle
- start_stop  input  1  debounced button level; acts on rising edge
- lap_clr  input  1  debounced button level; acts on rising edge
- d0  output  4  tenths digit, BCD 0-9
- d1  output  4  seconds ones, BCD 0-9
- d2  output  4  seconds tens, 0..SEC_TENS_MOD-1
- d3  output  4  minutes, BCD 0-9
- lap  output  1  one-cycle strobe; downstream registers load d0..d3 while it is high
- running  output  1  high in the RUNNING state
- overflow  output  1  sticky flag set at the 9:59.9 rollover
- lap_count  output  LAP_CNT_W  number of laps taken; saturates at all-ones

Behaviour:
- Reset (synchronous, active-high, clk rising edge):
  - State goes to IDLE.
  - d0..d3 = 0, lap = 0, running = 0, overflow = 0, lap_count = 0.
  - Edge-detect history registers are set to 1, so a button held through reset does not fire.
  - Reset has priority over every other input.
- Edge detect:
  - ss_ev = start_stop & ~start_stop_q; lc_ev = lap_clr & ~lap_clr_q.
  - Both _q registers update every cycle.
  - A level held high produces exactly one event.
- States: IDLE, RUNNING, STOPPED.
  - IDLE: ss_ev -> RUNNING. lc_ev is ignored.
  - RUNNING: ss_ev -> STOPPED. lc_ev stays in RUNNING and registers lap = 1 for the next cycle only; lap_count increments, holding at all-ones.
  - STOPPED: ss_ev -> RUNNING (resume; digits kept). lc_ev -> IDLE and clears d0..d3, lap_count and overflow.
  - Simultaneous ss_ev and lc_ev: ss_ev wins and lc_ev is dropped, in every state.
- Counting: the count advances only when the current state is RUNNING and tick = 1.
  - A tick in the same cycle as the ss_ev that leaves IDLE or STOPPED is not counted.
  - A tick in the same cycle as the ss_ev that leaves RUNNING is counted.
- Cascade:
  - d0 increments per counted tick and wraps 9 -> 0 with carry.
  - d1 advances on d0 carry and wraps 9 -> 0 with carry.
  - d2 advances on d1 carry and wraps SEC_TENS_MOD-1 -> 0 with carry.
  - d3 advances on d2 carry. At d3 = 9 with a carry in, the full-count (9:59.9 + 1) handling applies; see Optional Feature.
  - All digit updates are a single-cycle registered next-state. There are no intermediate invalid BCD values.
- Lap timing:
  - lap is a registered output: it is high in the cycle after the lap_clr edge cycle.
  - Digits visible while lap = 1 include any tick counted in the lc_ev cycle. That value is the captured lap time.
  - Back-to-back lap events need at least 2 cycles between them because of the edge detect. Each event yields its own one-cycle strobe.
- running = (state == RUNNING), registered; it updates on the same edge as the state.
- Reset mid-count or mid-strobe: lap drops to 0 on the reset edge and all outputs return to reset values.

Optional Feature:
- Macro: STOPWATCH_WRAP_EN.
- Defined: at 9:59.9 a counted tick wraps all digits to 0:00.0, sets overflow (sticky) and stays in RUNNING.
- Undefined: at 9:59.9 a counted tick leaves the digits frozen at 9:59.9, sets overflow, and forces the state to STOPPED (running = 0). Later ticks have no effect. lap_clr then clears to IDLE as normal.

Test Plan:
- Reset with start_stop held high, then release and press again -> no event while held; first real press gives running = 1; digits stay 0:00.0.
- Start, then 125 counted ticks (tick every cycle) -> d3 = 0, d2 = 1, d1 = 2, d0 = 5; stop; 10 more ticks -> digits unchanged.
- Running at 0:03.4: lap_clr edge coincident with a tick -> next cycle lap = 1 with digits 0:03.5, lap_count = 1; lap low the cycle after.
- Stopped at 0:03.9: start_stop and lap_clr edges in the same cycle -> resumes to RUNNING, no clear, lap stays 0.
- Count 5999 ticks to 9:59.9, then one more tick -> with STOPWATCH_WRAP_EN: 0:00.0, overflow = 1, running = 1; without it: 9:59.9, overflow = 1, running = 0.
- 17 lap events while running -> lap_count saturates at 15; stop then lap_clr -> IDLE, digits 0, lap_count 0, overflow 0.

Source files
------------

// File: rtl/stopwatch_counter.sv
// rtl/stopwatch_counter.sv - M:SS.t BCD stopwatch core with start/stop/lap/clear control
//
// Purpose:
//   Four-digit BCD time count (d3:d2d1.d0) advanced by an external tick
//   enable, controlled by a start/stop and a lap/clear button. Emits a
//   one-cycle lap strobe during which downstream lap registers capture
//   d0..d3.
//
// Optional feature macro: STOPWATCH_WRAP_EN
//   defined   - 9:59.9 + tick wraps to 0:00.0, sets overflow, keeps running
//   undefined - 9:59.9 + tick freezes the digits, sets overflow, stops
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   tick        in   one-cycle count enable (10 Hz for tenths)
//   start_stop  in   debounced button level, acts on rising edge
//   lap_clr     in   debounced button level, acts on rising edge
//   d0          out  tenths digit, 0-9
//   d1          out  seconds ones, 0-9
//   d2          out  seconds tens, 0..SEC_TENS_MOD-1
//   d3          out  minutes, 0-9
//   lap         out  one-cycle lap strobe
//   running     out  high in RUNNING
//   overflow    out  sticky full-count flag
//   lap_count   out  saturating number of laps taken

module stopwatch_counter #(
  parameter int SEC_TENS_MOD = 6,
  parameter int LAP_CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 start_stop,
  input  logic                 lap_clr,
  output logic [3:0]           d0,
  output logic [3:0]           d1,
  output logic [3:0]           d2,
  output logic [3:0]           d3,
  output logic                 lap,
  output logic                 running,
  output logic                 overflow,
  output logic [LAP_CNT_W-1:0] lap_count
);

`ifdef STOPWATCH_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam logic [3:0] D2_MAX = 4'(SEC_TENS_MOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUNNING,
    ST_STOPPED
  } state_e;

  state_e                 state_q;
  logic                   ss_q;
  logic                   lc_q;
  logic [3:0]             d0_q, d1_q, d2_q, d3_q;
  logic [3:0]             d0_d, d1_d, d2_d, d3_d;
  logic                   lap_q;
  logic                   running_q;
  logic                   overflow_q;
  logic [LAP_CNT_W-1:0]   lap_count_q;

  logic ss_ev;
  logic lc_ev;
  logic count_en;
  logic c0, c1, c2;
  logic full;

  // Rising-edge events; history regs reset to 1 so a held button is ignored.
  assign ss_ev = start_stop & ~ss_q;
  assign lc_ev = lap_clr & ~lc_q;

  // The count uses the current state only, so a tick coincident with the
  // press that starts counting is not counted, while one coincident with
  // the press that stops counting is.
  assign count_en = (state_q == ST_RUNNING) && tick;

  assign c0   = (d0_q == 4'd9);
  assign c1   = c0 && (d1_q == 4'd9);
  assign c2   = c1 && (d2_q == D2_MAX);
  assign full = c2 && (d3_q == 4'd9);

  // Whole-cascade next value computed in one step so no intermediate
  // non-BCD value is ever registered.
  always_comb begin
    d0_d = d0_q;
    d1_d = d1_q;
    d2_d = d2_q;
    d3_d = d3_q;
    if (count_en) begin
      if (full) begin
        if (WRAP_EN) begin
          d0_d = 4'd0;
          d1_d = 4'd0;
          d2_d = 4'd0;
          d3_d = 4'd0;
        end
      end else begin
        d0_d = c0 ? 4'd0 : d0_q + 4'd1;
        if (c0) d1_d = c1 ? 4'd0 : d1_q + 4'd1;
        if (c1) d2_d = c2 ? 4'd0 : d2_q + 4'd1;
        if (c2) d3_d = d3_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ss_q        <= 1'b1;
      lc_q        <= 1'b1;
      d0_q        <= 4'd0;
      d1_q        <= 4'd0;
      d2_q        <= 4'd0;
      d3_q        <= 4'd0;
      lap_q       <= 1'b0;
      running_q   <= 1'b0;
      overflow_q  <= 1'b0;
      lap_count_q <= '0;
    end else begin
      ss_q  <= start_stop;
      lc_q  <= lap_clr;
      lap_q <= 1'b0;
      d0_q  <= d0_d;
      d1_q  <= d1_d;
      d2_q  <= d2_d;
      d3_q  <= d3_d;
      if (count_en && full) overflow_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (ss_ev) begin
            state_q   <= ST_RUNNING;
            running_q <= 1'b1;
          end
        end

        ST_RUNNING: begin
          if (ss_ev) begin
            state_q   <= ST_STOPPED;
            running_q <= 1'b0;
          end else if (lc_ev) begin
            lap_q <= 1'b1;
            if (lap_count_q != {LAP_CNT_W{1'b1}})
              lap_count_q <= lap_count_q + LAP_CNT_W'(1);
          end
          // Without wrap, reaching the full count forces a stop.
          if (!WRAP_EN && count_en && full) begin
            state_q   <= ST_STOPPED;
            running_q <= 1'b0;
          end
        end

        ST_STOPPED: begin
          if (ss_ev) begin
            state_q   <= ST_RUNNING;
            running_q <= 1'b1;
          end else if (lc_ev) begin
            state_q     <= ST_IDLE;
            running_q   <= 1'b0;
            d0_q        <= 4'd0;
            d1_q        <= 4'd0;
            d2_q        <= 4'd0;
            d3_q        <= 4'd0;
            lap_count_q <= '0;
            overflow_q  <= 1'b0;
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign d0        = d0_q;
  assign d1        = d1_q;
  assign d2        = d2_q;
  assign d3        = d3_q;
  assign lap       = lap_q;
  assign running   = running_q;
  assign overflow  = overflow_q;
  assign lap_count = lap_count_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// tb/tb_stopwatch_counter.sv - directed self-checking bench for stopwatch_counter

module tb_stopwatch_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       start_stop;
  logic       lap_clr;
  logic [3:0] d0, d1, d2, d3;
  logic       lap;
  logic       running;
  logic       overflow;
  logic [3:0] lap_count;

  int n_checks = 0;
  int n_fail   = 0;

  stopwatch_counter #(
    .SEC_TENS_MOD (6),
    .LAP_CNT_W    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .start_stop (start_stop),
    .lap_clr    (lap_clr),
    .d0         (d0),
    .d1         (d1),
    .d2         (d2),
    .d3         (d3),
    .lap        (lap),
    .running    (running),
    .overflow   (overflow),
    .lap_count  (lap_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Digits packed as a decimal M SS t number for compact comparisons.
  function automatic int digits();
    return int'(d3) * 1000 + int'(d2) * 100 + int'(d1) * 10 + int'(d0);
  endfunction

  initial begin
    rst        = 1'b1;
    tick       = 1'b0;
    start_stop = 1'b1;
    lap_clr    = 1'b0;
    cyc(2);
    check_eq("rst_digits", digits(), 0);
    check_eq("rst_running", running, 0);
    check_eq("rst_lap", lap, 0);
    check_eq("rst_overflow", overflow, 0);
    check_eq("rst_lap_count", lap_count, 0);

    // Button held through reset: no event.
    rst = 1'b0;
    cyc(3);
    check_eq("held_no_start", running, 0);
    start_stop = 1'b0;
    cyc();
    start_stop = 1'b1;
    cyc();
    check_eq("first_press_running", running, 1);
    check_eq("first_press_digits", digits(), 0);
    start_stop = 1'b0;

    // 125 ticks -> 0:12.5
    tick = 1'b1;
    cyc(125);
    check_eq("count_125", digits(), 125);
    tick = 1'b0;
    start_stop = 1'b1;
    cyc();
    check_eq("stop_running", running, 0);
    start_stop = 1'b0;
    tick = 1'b1;
    cyc(10);
    tick = 1'b0;
    check_eq("stopped_ticks_ignored", digits(), 125);

    // Clear from STOPPED.
    lap_clr = 1'b1;
    cyc();
    lap_clr = 1'b0;
    check_eq("clear_digits", digits(), 0);
    check_eq("clear_running", running, 0);
    cyc();

    // Start with a coincident tick: not counted.
    start_stop = 1'b1;
    tick = 1'b1;
    cyc();
    start_stop = 1'b0;
    check_eq("start_tick_not_counted", digits(), 0);
    check_eq("start_running", running, 1);
    cyc(34);
    check_eq("count_34", digits(), 34);

    // Lap coincident with a tick captures 0:03.5.
    lap_clr = 1'b1;
    cyc();
    lap_clr = 1'b0;
    tick = 1'b0;
    check_eq("lap_strobe", lap, 1);
    check_eq("lap_digits", digits(), 35);
    check_eq("lap_count_1", lap_count, 1);
    cyc();
    check_eq("lap_one_cycle", lap, 0);

    // Stop with a coincident tick: counted -> 0:03.9.
    tick = 1'b1;
    cyc(3);
    start_stop = 1'b1;
    cyc();
    start_stop = 1'b0;
    tick = 1'b0;
    check_eq("stop_tick_counted", digits(), 39);
    check_eq("stop2_running", running, 0);
    cyc();

    // Simultaneous edges in STOPPED: resume wins, no clear.
    start_stop = 1'b1;
    lap_clr = 1'b1;
    cyc();
    check_eq("simul_running", running, 1);
    check_eq("simul_digits", digits(), 39);
    check_eq("simul_lap", lap, 0);
    check_eq("simul_lap_count", lap_count, 1);
    start_stop = 1'b0;
    lap_clr = 1'b0;
    cyc();
    check_eq("simul_lap_after", lap, 0);

    // 17 more laps: saturate at 15.
    for (int i = 0; i < 17; i++) begin
      lap_clr = 1'b1;
      cyc();
      check_eq($sformatf("lap_pulse_%0d", i), lap, 1);
      lap_clr = 1'b0;
      cyc();
      check_eq($sformatf("lap_drop_%0d", i), lap, 0);
    end
    check_eq("lap_count_sat", lap_count, 15);

    start_stop = 1'b1;
    cyc();
    start_stop = 1'b0;
    cyc();
    lap_clr = 1'b1;
    cyc();
    lap_clr = 1'b0;
    check_eq("clr2_running", running, 0);
    check_eq("clr2_digits", digits(), 0);
    check_eq("clr2_lap_count", lap_count, 0);
    check_eq("clr2_overflow", overflow, 0);
    cyc();

    // Full count: 5999 ticks -> 9:59.9, then one more.
    start_stop = 1'b1;
    cyc();
    start_stop = 1'b0;
    tick = 1'b1;
    cyc(5999);
    check_eq("full_digits", digits(), 9599);
    check_eq("full_no_overflow", overflow, 0);
    cyc();
    check_eq("ovf_flag", overflow, 1);
`ifdef STOPWATCH_WRAP_EN
    check_eq("ovf_wrap_digits", digits(), 0);
    check_eq("ovf_wrap_running", running, 1);
    cyc(5);
    check_eq("ovf_wrap_continue", digits(), 5);
    check_eq("ovf_sticky", overflow, 1);
`else
    check_eq("ovf_freeze_digits", digits(), 9599);
    check_eq("ovf_freeze_running", running, 0);
    cyc(5);
    check_eq("ovf_freeze_hold", digits(), 9599);
    check_eq("ovf_sticky", overflow, 1);
`endif
    tick = 1'b0;

    // Reset mid-count returns everything to reset values.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_eq("rst2_digits", digits(), 0);
    check_eq("rst2_overflow", overflow, 0);
    check_eq("rst2_running", running, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
